// File: rtl/bcd_seq_mul.sv
// rtl/bcd_seq_mul.sv - iterative packed-BCD multiplier (BCD->bin, multiply, double dabble)
// Optional leading-zero blanking of product_bcd: define BCD_MUL_LEADING_BLANK_EN.
module bcd_seq_mul #(
  parameter int DIGITS = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [4*DIGITS-1:0]   a_bcd,
  input  logic [4*DIGITS-1:0]   b_bcd,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [8*DIGITS-1:0]   product_bcd
);

  function automatic int calc_aw(input int d);
    longint p;
    longint one;
    int     w;
    p   = 1;
    one = 1;
    w   = 0;
    for (int i = 0; i < d; i++) p = p * 10;
    while ((one << w) < p) w++;
    return w;
  endfunction

  localparam int AW = calc_aw(DIGITS);
  localparam int PW = 2 * AW;
  localparam int NB = 4 * DIGITS;
  localparam int BW = 8 * DIGITS;
  localparam int CW = 6;

  typedef enum logic [2:0] {S_IDLE, S_REJ, S_CONV, S_MUL, S_DAB} state_t;

  state_t          state, state_nx;
  logic [CW-1:0]   cnt;
  logic [NB-1:0]   a_sr, b_sr;
  logic [AW-1:0]   bin_a, bin_b;
  logic [BW-1:0]   bcd, bcd_nx, load_val;
  logic [BW-2:0]   bcd_adj;
  logic [PW-1:0]   bin, bin_nx, prod;
  logic            ops_ok, conv_last, dab_last;
  logic            done_nx, err_nx;

  always_comb begin
    ops_ok = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (a_bcd[4*i +: 4] > 4'd9 || b_bcd[4*i +: 4] > 4'd9) ops_ok = 1'b0;
    end
  end

  // The top column only needs its low three bits: its carry would shift out
  // of a product that always fits in 2*DIGITS digits.
  always_comb begin
    logic [3:0] t;
    bcd_adj = '0;
    t       = '0;
    for (int i = 0; i < 2*DIGITS - 1; i++) begin
      t = (bcd[4*i +: 4] >= 4'd5) ? bcd[4*i +: 4] + 4'd3 : bcd[4*i +: 4];
      bcd_adj[4*i +: 4] = t;
    end
    t = (bcd[BW-1 -: 4] >= 4'd5) ? bcd[BW-1 -: 4] + 4'd3 : bcd[BW-1 -: 4];
    bcd_adj[BW-2 -: 3] = t[2:0];
  end

  assign bcd_nx    = {bcd_adj, bin[PW-1]};
  assign bin_nx    = {bin[PW-2:0], 1'b0};
  assign prod      = PW'(bin_a) * PW'(bin_b);
  assign conv_last = (cnt == CW'(DIGITS - 1));
  assign dab_last  = (cnt == CW'(PW - 1));

`ifdef BCD_MUL_LEADING_BLANK_EN
  function automatic logic [BW-1:0] blank_lead(input logic [BW-1:0] v);
    logic [BW-1:0] r;
    logic          lead;
    r    = v;
    lead = 1'b1;
    for (int i = 2*DIGITS - 1; i >= 1; i--) begin
      if (lead && v[4*i +: 4] == 4'd0) r[4*i +: 4] = 4'hF;
      else lead = 1'b0;
    end
    return r;
  endfunction
  assign load_val = blank_lead(bcd_nx);
`else
  assign load_val = bcd_nx;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
      done  <= 1'b0;
      err   <= 1'b0;
    end else begin
      state <= state_nx;
      done  <= done_nx;
      err   <= err_nx;
    end
  end

  always_comb begin
    state_nx = state;
    done_nx  = 1'b0;
    err_nx   = 1'b0;
    case (state)
      S_IDLE: if (start) begin
        if (ops_ok) begin
          state_nx = S_CONV;
        end else begin
          state_nx = S_REJ;
          done_nx  = 1'b1;
          err_nx   = 1'b1;
        end
      end
      S_REJ:  state_nx = S_IDLE;
      S_CONV: if (conv_last) state_nx = S_MUL;
      S_MUL:  state_nx = S_DAB;
      S_DAB:  if (dab_last) begin
        state_nx = S_IDLE;
        done_nx  = 1'b1;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  assign busy = (state == S_CONV) || (state == S_MUL) || (state == S_DAB);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt         <= '0;
      a_sr        <= '0;
      b_sr        <= '0;
      bin_a       <= '0;
      bin_b       <= '0;
      bcd         <= '0;
      bin         <= '0;
      product_bcd <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          cnt <= '0;
          if (start && ops_ok) begin
            a_sr  <= a_bcd;
            b_sr  <= b_bcd;
            bin_a <= '0;
            bin_b <= '0;
          end
        end
        S_CONV: begin
          bin_a <= bin_a * AW'(10) + AW'(a_sr[NB-1 -: 4]);
          bin_b <= bin_b * AW'(10) + AW'(b_sr[NB-1 -: 4]);
          a_sr  <= a_sr << 4;
          b_sr  <= b_sr << 4;
          cnt   <= conv_last ? '0 : cnt + CW'(1);
        end
        S_MUL: begin
          bcd <= '0;
          bin <= prod;
          cnt <= '0;
        end
        S_DAB: begin
          bcd <= bcd_nx;
          bin <= bin_nx;
          cnt <= cnt + CW'(1);
          if (dab_last) product_bcd <= load_val;
        end
        default: cnt <= '0;
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_seq_mul.sv
// tb/tb_bcd_seq_mul.sv - directed self-checking bench for bcd_seq_mul (DIGITS 2, 4, 1)
module tb_bcd_seq_mul;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        start, start4, start1;
  logic [7:0]  a_bcd, b_bcd;
  logic [15:0] a4, b4;
  logic [3:0]  a1, b1;
  logic        busy, done, err, busy4, done4, err4, busy1, done1, err1;
  logic [15:0] product;
  logic [31:0] product4;
  logic [7:0]  product1;

  int checks = 0;
  int errors = 0;

`ifdef BCD_MUL_LEADING_BLANK_EN
  localparam logic [15:0] EXP_1234 = 16'hF408;
  localparam logic [15:0] EXP_ZERO = 16'hFFF0;
  localparam logic [15:0] EXP_100  = 16'hF100;
`else
  localparam logic [15:0] EXP_1234 = 16'h0408;
  localparam logic [15:0] EXP_ZERO = 16'h0000;
  localparam logic [15:0] EXP_100  = 16'h0100;
`endif

  bcd_seq_mul #(.DIGITS(2)) u_dut (
    .clk(clk), .rst(rst), .start(start), .a_bcd(a_bcd), .b_bcd(b_bcd),
    .busy(busy), .done(done), .err(err), .product_bcd(product)
  );
  bcd_seq_mul #(.DIGITS(4)) u_dut4 (
    .clk(clk), .rst(rst), .start(start4), .a_bcd(a4), .b_bcd(b4),
    .busy(busy4), .done(done4), .err(err4), .product_bcd(product4)
  );
  bcd_seq_mul #(.DIGITS(1)) u_dut1 (
    .clk(clk), .rst(rst), .start(start1), .a_bcd(a1), .b_bcd(b1),
    .busy(busy1), .done(done1), .err(err1), .product_bcd(product1)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic pulse(input int sel, input logic [15:0] a, input logic [15:0] b);
    @(negedge clk);
    case (sel)
      0:       begin a_bcd = a[7:0]; b_bcd = b[7:0]; start  = 1'b1; end
      1:       begin a4 = a;         b4 = b;         start4 = 1'b1; end
      default: begin a1 = a[3:0];    b1 = b[3:0];    start1 = 1'b1; end
    endcase
    @(posedge clk);
    #1;
    start = 1'b0; start4 = 1'b0; start1 = 1'b0;
  endtask

  task automatic wait_done(input int sel, output int n, output logic e);
    logic d;
    n = -1;
    e = 1'b0;
    for (int i = 1; i <= 100; i++) begin
      @(posedge clk);
      @(negedge clk);
      d = (sel == 0) ? done : (sel == 1) ? done4 : done1;
      if (d) begin
        n = i;
        e = (sel == 0) ? err : (sel == 1) ? err4 : err1;
        break;
      end
    end
  endtask

  int   n, n_first, n_done;
  logic e;

  initial begin
    rst = 1'b1;
    start = 1'b0; start4 = 1'b0; start1 = 1'b0;
    a_bcd = '0; b_bcd = '0; a4 = '0; b4 = '0; a1 = '0; b1 = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_prod", product, 0);
    check("rst_prod4", product4, 0);
    check("rst_prod1", product1, 0);
    @(negedge clk);
    rst = 1'b0;

    pulse(0, 16'h12, 16'h34);
    check("t1_busy_e0", busy, 1);
    wait_done(0, n, e);
    check("t1_lat", n, 17);
    check("t1_err", e, 0);
    check("t1_prod", product, EXP_1234);
    check("t1_busy_done", busy, 0);

    // start held high across the done cycle
    @(negedge clk);
    a_bcd = 8'h99; b_bcd = 8'h99; start = 1'b1;
    wait_done(0, n, e);
    check("b2b1_lat", n, 18);
    check("b2b1_prod", product, 16'h9801);
    a_bcd = 8'h00; b_bcd = 8'h57;
    wait_done(0, n, e);
    start = 1'b0;
    check("b2b2_interval", n, 18);
    check("b2b2_prod", product, EXP_ZERO);

    pulse(0, 16'h1A, 16'h05);
    check("rej_done", done, 1);
    check("rej_err", err, 1);
    check("rej_busy", busy, 0);
    check("rej_prod", product, EXP_ZERO);
    @(posedge clk);
    #1;
    check("rej_done_off", done, 0);
    check("rej_err_off", err, 0);
    check("rej_busy_off", busy, 0);

    pulse(0, 16'h12, 16'h34);
    n_done = 0;
    n_first = 0;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk);
      #1;
      start = (i == 3 || i == 4 || i == 9);
      a_bcd = 8'h99;
      b_bcd = 8'($urandom);
      @(negedge clk);
      if (done) begin
        n_done++;
        if (n_first == 0) n_first = i;
      end
    end
    start = 1'b0;
    check("ign_done_cnt", n_done, 1);
    check("ign_lat", n_first, 17);
    check("ign_prod", product, EXP_1234);

    pulse(0, 16'h12, 16'h34);
    repeat (5) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check("arst_busy", busy, 0);
    check("arst_done", done, 0);
    check("arst_err", err, 0);
    check("arst_prod", product, 0);
    @(negedge clk);
    rst = 1'b0;
    n_done = 0;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      if (done) n_done++;
    end
    check("arst_no_done", n_done, 0);
    pulse(0, 16'h25, 16'h04);
    wait_done(0, n, e);
    check("post_rst_lat", n, 17);
    check("post_rst_prod", product, EXP_100);

    pulse(1, 16'h9999, 16'h9999);
    wait_done(1, n, e);
    check("d4_lat", n, 33);
    check("d4_prod", product4, 32'h99980001);

    pulse(2, 16'h9, 16'h9);
    wait_done(2, n, e);
    check("d1_lat", n, 10);
    check("d1_prod", product1, 8'h81);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
